// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and hazard helper functions for hazard_ctrl.
package hazard_pkg;

  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned DEF_CNT_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t STALL = 2'd2;
  localparam state_t JALR  = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Stall cycles one source operand needs before ID may proceed.
  function automatic logic [1:0] stall_need(input logic is_branch, input logic ex_hit,
                                            input logic ex_load, input logic mem_hit,
                                            input logic mem_load);
    logic [1:0] n;
    n = 2'd0;
    if (ex_hit && ex_load) n = 2'd1;
    if (is_branch) begin
      if (ex_hit) n = ex_load ? 2'd2 : 2'd1;
      else if (mem_hit && mem_load) n = 2'd1;
    end
    return n;
  endfunction

  // A load in MEM has no data yet, so it cannot feed the ID compare.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic mem_load,
                                         input logic wb_hit);
    if (mem_hit && !mem_load) return FWD_MEM;
    if (wb_hit) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Destination/source register comparator; x0 never matches.
module hazard_match #(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] rd,
  input  logic          we,
  input  logic [AW-1:0] rs,
  input  logic          use_rs,
  output logic          hit
);

  assign hit = we && use_rs && (rd != '0) && (rd == rs);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_CNT_EN to implement the stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    id_rs1_i,
  input  logic [AW-1:0]    id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_is_branch_i,
  input  logic             id_is_jal_i,
  input  logic             id_is_jalr_i,
  input  logic             id_taken_i,
  input  logic [AW-1:0]    ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_is_load_i,
  input  logic [AW-1:0]    mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic             mem_is_load_i,
  input  logic [AW-1:0]    wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             jalr_sel_o,
  output logic [1:0]       fwd_rs1_o,
  output logic [1:0]       fwd_rs2_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t     state_q, state_d;
  logic [1:0] stall_left_q, stall_left_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;

  hazard_match #(.AW(AW)) u_ex_rs1 (
    .rd(ex_rd_i), .we(ex_reg_write_i), .rs(id_rs1_i), .use_rs(id_use_rs1_i), .hit(ex_hit1)
  );
  hazard_match #(.AW(AW)) u_ex_rs2 (
    .rd(ex_rd_i), .we(ex_reg_write_i), .rs(id_rs2_i), .use_rs(id_use_rs2_i), .hit(ex_hit2)
  );
  hazard_match #(.AW(AW)) u_mem_rs1 (
    .rd(mem_rd_i), .we(mem_reg_write_i), .rs(id_rs1_i), .use_rs(id_use_rs1_i), .hit(mem_hit1)
  );
  hazard_match #(.AW(AW)) u_mem_rs2 (
    .rd(mem_rd_i), .we(mem_reg_write_i), .rs(id_rs2_i), .use_rs(id_use_rs2_i), .hit(mem_hit2)
  );
  hazard_match #(.AW(AW)) u_wb_rs1 (
    .rd(wb_rd_i), .we(wb_reg_write_i), .rs(id_rs1_i), .use_rs(id_use_rs1_i), .hit(wb_hit1)
  );
  hazard_match #(.AW(AW)) u_wb_rs2 (
    .rd(wb_rd_i), .we(wb_reg_write_i), .rs(id_rs2_i), .use_rs(id_use_rs2_i), .hit(wb_hit2)
  );

  logic [1:0] need1, need2, need;

  always_comb begin
    need1 = stall_need(id_is_branch_i, ex_hit1, ex_is_load_i, mem_hit1, mem_is_load_i);
    need2 = stall_need(id_is_branch_i, ex_hit2, ex_is_load_i, mem_hit2, mem_is_load_i);
    need  = (need1 > need2) ? need1 : need2;
  end

  logic stall_cyc;

  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    jalr_sel_o     = 1'b0;
    fwd_rs1_o      = FWD_RF;
    fwd_rs2_o      = FWD_RF;
    stall_cyc      = 1'b0;
    state_d        = state_q;
    stall_left_d   = stall_left_q;

    case (state_q)
      IDLE: begin
        id_ex_bubble_o = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (need != 2'd0) begin
          // Stall wins over any redirect of the held instruction.
          id_ex_bubble_o = 1'b1;
          stall_cyc      = 1'b1;
          stall_left_d   = need - 2'd1;
          state_d        = (need == 2'd2) ? STALL : RUN;
        end else begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
          fwd_rs1_o     = fwd_sel(mem_hit1, mem_is_load_i, wb_hit1);
          fwd_rs2_o     = fwd_sel(mem_hit2, mem_is_load_i, wb_hit2);
          if (id_is_jalr_i) begin
            pc_write_o    = 1'b0;
            if_id_flush_o = 1'b1;
            state_d       = JALR;
          end else if (id_is_jal_i || (id_is_branch_i && id_taken_i)) begin
            if_id_flush_o = 1'b1;
          end
        end
      end
      STALL: begin
        id_ex_bubble_o = 1'b1;
        stall_cyc      = 1'b1;
        if (stall_left_q <= 2'd1) begin
          stall_left_d = 2'd0;
          state_d      = RUN;
        end else begin
          stall_left_d = stall_left_q - 2'd1;
        end
      end
      JALR: begin
        jalr_sel_o    = 1'b1;
        pc_write_o    = 1'b1;
        if_id_flush_o = 1'b1;
        if_id_write_o = 1'b1;
        state_d       = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      jalr_sel_o     = 1'b0;
      fwd_rs1_o      = FWD_RF;
      fwd_rs2_o      = FWD_RF;
      stall_cyc      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      stall_left_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_cyc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
  assign flush_cnt_o = rst_i ? '0 : flush_cnt_q;
`else
  logic unused_stall_cyc;
  assign unused_stall_cyc = stall_cyc;
  assign stall_cnt_o      = '0;
  assign flush_cnt_o      = '0;
`endif

endmodule
